// File: rtl/conv_host_pkg.sv
// Shared types and constants for the convolution host: state encoding, bank depths, layer selects.
// The TMO state exists only when CONV_HOST_TIMEOUT_EN is defined.
package conv_host_pkg;
   localparam int DATA_W    = 20;
   localparam int IMG_DEPTH = 4096;
   localparam int L0_DEPTH  = 4096;
   localparam int L1_DEPTH  = 1024;

   localparam logic [2:0] CSEL_L0 = 3'b001;
   localparam logic [2:0] CSEL_L1 = 3'b011;

   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_RUN,
      ST_DONE
`ifdef CONV_HOST_TIMEOUT_EN
      , ST_TMO
`endif
   } state_t;
endpackage

// File: rtl/conv_host_bank.sv
// Parametric-depth memory: one synchronous write port, N_RD asynchronous read ports.
module conv_host_bank
   import conv_host_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int N_RD  = 1,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  data_t         wdata,
   input  logic [AW-1:0] raddr [N_RD],
   output data_t         rdata [N_RD]
);

   data_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_comb begin
      for (int i = 0; i < N_RD; i++) rdata[i] = mem[raddr[i]];
   end

endmodule

// File: rtl/conv_host.sv
// Host-side controller for a convolution engine: image/L0/L1 banks, start handshake, readback.
// Optional watchdog and TMO state are compiled in with CONV_HOST_TIMEOUT_EN.
//
// state | meaning
// IDLE  | accept image preload, readback and start
// START | ready high, waiting for engine busy
// RUN   | engine busy, layer writes accepted
// DONE  | one-cycle done pulse
// TMO   | watchdog expired; start returns to IDLE
module conv_host
   import conv_host_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ready,
   input  logic        busy,
   input  logic [11:0] iaddr,
   output data_t       idata,
   input  logic        cwr,
   input  logic [11:0] caddr_wr,
   input  data_t       cdata_wr,
   input  logic        crd,
   input  logic [11:0] caddr_rd,
   output data_t       cdata_rd,
   input  logic [2:0]  csel,
   input  logic        load_valid,
   input  logic [11:0] load_addr,
   input  data_t       load_data,
   input  logic        start,
   input  logic        rb_en,
   input  logic        rb_sel,
   input  logic [11:0] rb_addr,
   output data_t       rb_data,
   output logic        done,
   output logic        err,
   output logic [12:0] wr_cnt0,
   output logic [10:0] wr_cnt1
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("conv_host: TIMEOUT_CYCLES must be at least 2");
   end

   state_t state_q, state_d;
   logic   start_acc, tmo_hit, in_run, in_idle;
   logic   we_img, we0, we1, cwr_bad;

   logic [11:0] img_raddr [1];
   data_t       img_rdata [1];
   logic [11:0] l0_raddr  [2];
   data_t       l0_rdata  [2];
   logic [9:0]  l1_raddr  [2];
   data_t       l1_rdata  [2];

   assign in_run  = (state_q == ST_RUN);
   assign in_idle = (state_q == ST_IDLE);

   assign we_img  = load_valid && in_idle;
   assign we0     = cwr && in_run && (csel == CSEL_L0);
   assign we1     = cwr && in_run && (csel == CSEL_L1) && (caddr_wr < 12'(L1_DEPTH));
   assign cwr_bad = cwr && !we0 && !we1;

   assign img_raddr[0] = iaddr;
   assign l0_raddr[0]  = caddr_rd;
   assign l0_raddr[1]  = rb_addr;
   assign l1_raddr[0]  = caddr_rd[9:0];
   assign l1_raddr[1]  = rb_addr[9:0];

   conv_host_bank #(.DEPTH(IMG_DEPTH), .N_RD(1)) u_img (
      .clk   (clk),
      .we    (we_img),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (img_raddr),
      .rdata (img_rdata)
   );

   conv_host_bank #(.DEPTH(L0_DEPTH), .N_RD(2)) u_l0 (
      .clk   (clk),
      .we    (we0),
      .waddr (caddr_wr),
      .wdata (cdata_wr),
      .raddr (l0_raddr),
      .rdata (l0_rdata)
   );

   conv_host_bank #(.DEPTH(L1_DEPTH), .N_RD(2)) u_l1 (
      .clk   (clk),
      .we    (we1),
      .waddr (caddr_wr[9:0]),
      .wdata (cdata_wr),
      .raddr (l1_raddr),
      .rdata (l1_rdata)
   );

   assign idata = img_rdata[0];

   always_comb begin
      cdata_rd = '0;
      if (crd) begin
         if (csel == CSEL_L0)      cdata_rd = l0_rdata[0];
         else if (csel == CSEL_L1) cdata_rd = l1_rdata[0];
      end
   end

`ifdef CONV_HOST_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0] tmo_cnt;

   // Down-counter loaded on start; terminal count at zero after TIMEOUT_CYCLES cycles in START/RUN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt <= '0;
      end else if (start_acc) begin
         tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
      end else if ((state_q == ST_START || in_run) && tmo_cnt != '0) begin
         tmo_cnt <= tmo_cnt - 1'b1;
      end
   end

   assign tmo_hit = (state_q == ST_START || in_run) && (tmo_cnt == '0);
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      ready     = 1'b0;
      done      = 1'b0;
      start_acc = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !load_valid) begin
               state_d   = ST_START;
               start_acc = 1'b1;
            end
         end
         ST_START: begin
            ready = 1'b1;
            if (busy) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!busy) state_d = ST_DONE;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
`ifdef CONV_HOST_TIMEOUT_EN
         ST_TMO: begin
            if (start) state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
`ifdef CONV_HOST_TIMEOUT_EN
      if (tmo_hit) state_d = ST_TMO;
`endif
   end

   // Error set takes priority over the clear that accompanies an accepted start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err     <= 1'b0;
         wr_cnt0 <= '0;
         wr_cnt1 <= '0;
      end else begin
         if (start_acc) begin
            err     <= 1'b0;
            wr_cnt0 <= '0;
            wr_cnt1 <= '0;
         end else begin
            if (we0 && !(&wr_cnt0)) wr_cnt0 <= wr_cnt0 + 1'b1;
            if (we1 && !(&wr_cnt1)) wr_cnt1 <= wr_cnt1 + 1'b1;
         end
         if (cwr_bad || tmo_hit) err <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                rb_data <= '0;
      else if (in_idle && rb_en) rb_data <= rb_sel ? l1_rdata[1] : l0_rdata[1];
   end

endmodule

// File: tb/tb_conv_host.sv
// Directed bench for conv_host: expected values queued at stimulus, popped and asserted at sample points.
module tb_conv_host;
   import conv_host_pkg::*;

   logic        clk = 1'b0;
   logic        reset, busy, cwr, crd, load_valid, start, rb_en, rb_sel;
   logic [11:0] iaddr, caddr_wr, caddr_rd, load_addr, rb_addr;
   logic [2:0]  csel;
   data_t       cdata_wr, load_data;
   logic        ready, done, err;
   data_t       idata, cdata_rd, rb_data;
   logic [12:0] wr_cnt0;
   logic [10:0] wr_cnt1;

   logic        start2 = 1'b0;
   logic        t_ready, t_done, t_err;
   data_t       t_idata, t_cdata_rd, t_rb_data;
   logic [12:0] t_wr_cnt0;
   logic [10:0] t_wr_cnt1;

   int          n_vec = 0;
   int          n_err = 0;
   int          ready_hi = 0;
   int          done_hi = 0;
   int          rbase, dbase;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   conv_host dut (
      .clk(clk), .reset(reset), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
      .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
      .cdata_rd(cdata_rd), .csel(csel), .load_valid(load_valid), .load_addr(load_addr),
      .load_data(load_data), .start(start), .rb_en(rb_en), .rb_sel(rb_sel), .rb_addr(rb_addr),
      .rb_data(rb_data), .done(done), .err(err), .wr_cnt0(wr_cnt0), .wr_cnt1(wr_cnt1)
   );

   // Second instance with a short watchdog; engine never raises busy.
   conv_host #(.TIMEOUT_CYCLES(16)) dut_tmo (
      .clk(clk), .reset(reset), .ready(t_ready), .busy(1'b0), .iaddr(iaddr), .idata(t_idata),
      .cwr(1'b0), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(1'b0), .caddr_rd(caddr_rd),
      .cdata_rd(t_cdata_rd), .csel(csel), .load_valid(1'b0), .load_addr(load_addr),
      .load_data(load_data), .start(start2), .rb_en(1'b0), .rb_sel(1'b0), .rb_addr(rb_addr),
      .rb_data(t_rb_data), .done(t_done), .err(t_err), .wr_cnt0(t_wr_cnt0), .wr_cnt1(t_wr_cnt1)
   );

   always @(negedge clk) begin
      if (ready === 1'b1) ready_hi++;
      if (done === 1'b1)  done_hi++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_v(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
         return;
      end
      e = exp_q.pop_front();
      assert (obs === e) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      reset = 1'b1; busy = 0; cwr = 0; crd = 0; load_valid = 0; start = 0; rb_en = 0; rb_sel = 0;
      iaddr = 0; caddr_wr = 0; caddr_rd = 0; load_addr = 0; rb_addr = 0; csel = 0;
      cdata_wr = 0; load_data = 0;
      repeat (3) tick();
      repeat (6) expect_v(0);
      expect_v(32'(ST_IDLE));
      check("rst_ready", 32'(ready));
      check("rst_done", 32'(done));
      check("rst_err", 32'(err));
      check("rst_wr_cnt0", 32'(wr_cnt0));
      check("rst_wr_cnt1", 32'(wr_cnt1));
      check("rst_rb_data", 32'(rb_data));
      check("rst_state", 32'(dut.state_q));
      reset = 1'b0;
      tick();

      // image preload and combinational read
      load_valid = 1; load_addr = 12'd0; load_data = 20'h0A89E; expect_v(32'h0A89E);
      tick();
      load_addr = 12'd4095; load_data = 20'hFFFFF; expect_v(32'hFFFFF);
      tick();
      load_valid = 0; iaddr = 12'd0; #1;
      check("idata_0", 32'(idata));
      iaddr = 12'd4095; #1;
      check("idata_4095", 32'(idata));

      // load wins over start
      load_valid = 1; start = 1; load_addr = 12'd7; load_data = 20'h3C3C3;
      expect_v(32'h3C3C3); expect_v(32'(ST_IDLE)); expect_v(0);
      tick();
      load_valid = 0; start = 0; iaddr = 12'd7; #1;
      check("load_start_idata", 32'(idata));
      check("load_start_state", 32'(dut.state_q));
      check("load_start_ready", 32'(ready));

      // start handshake: busy raised two cycles after START entry
      rbase = ready_hi;
      start = 1; expect_v(32'(ST_START));
      tick();
      start = 0;
      check("start_state", 32'(dut.state_q));
      tick(); tick();
      busy = 1; expect_v(32'(ST_RUN)); expect_v(3);
      tick();
      check("run_state", 32'(dut.state_q));
      check("ready_cycles", 32'(ready_hi - rbase));

      // layer writes in RUN
      cwr = 1; csel = CSEL_L0; caddr_wr = 12'd63; cdata_wr = 20'h00123;
      tick();
      csel = CSEL_L1; caddr_wr = 12'd0; cdata_wr = 20'h55555;
      tick();
      caddr_wr = 12'd1023; cdata_wr = 20'hABCDE;
      tick();
      cwr = 0;
      crd = 1; csel = CSEL_L0; caddr_rd = 12'd63; expect_v(32'h00123); expect_v(1); #1;
      check("cdata_l0_63", 32'(cdata_rd));
      check("wr_cnt0_one", 32'(wr_cnt0));
      csel = CSEL_L1; caddr_rd = 12'h7FF; expect_v(32'hABCDE); #1;
      check("cdata_l1_idx", 32'(cdata_rd));
      csel = 3'b010; expect_v(0); #1;
      check("cdata_bad_csel", 32'(cdata_rd));
      crd = 0; csel = CSEL_L0; caddr_rd = 12'd63; expect_v(0); expect_v(0); #1;
      check("cdata_no_crd", 32'(cdata_rd));
      check("err_clean", 32'(err));

      // illegal L1 address
      cwr = 1; csel = CSEL_L1; caddr_wr = 12'd1024; cdata_wr = 20'hFFFFF;
      expect_v(1); expect_v(2); expect_v(32'h55555);
      tick();
      cwr = 0;
      check("err_l1_oob", 32'(err));
      check("wr_cnt1_oob", 32'(wr_cnt1));
      crd = 1; caddr_rd = 12'd0; #1;
      check("l1_0_intact", 32'(cdata_rd));
      crd = 0;

      // busy falls -> DONE pulse -> IDLE
      repeat (95) tick();
      dbase = done_hi;
      busy = 0; expect_v(32'(ST_DONE)); expect_v(1);
      tick();
      check("done_state", 32'(dut.state_q));
      check("done_high", 32'(done));
      expect_v(32'(ST_IDLE)); expect_v(0);
      tick();
      check("post_done_state", 32'(dut.state_q));
      check("post_done_low", 32'(done));
      tick(); tick();
      expect_v(1); expect_v(1);
      check("done_cycles", 32'(done_hi - dbase));
      check("err_sticky", 32'(err));

      // readback
      rb_en = 1; rb_sel = 0; rb_addr = 12'd63; expect_v(32'h00123);
      tick();
      rb_en = 0;
      check("rb_l0_63", 32'(rb_data));
      rb_en = 1; rb_sel = 1; rb_addr = 12'hBFF; expect_v(32'hABCDE);
      tick();
      rb_en = 0;
      check("rb_l1_idx", 32'(rb_data));
      rb_sel = 0; rb_addr = 12'd0; expect_v(32'hABCDE);
      tick();
      check("rb_hold", 32'(rb_data));

      // second run: start clears status, write outside RUN flags err
      start = 1; expect_v(0); expect_v(0); expect_v(0);
      tick();
      start = 0;
      check("restart_err", 32'(err));
      check("restart_cnt0", 32'(wr_cnt0));
      check("restart_cnt1", 32'(wr_cnt1));
      cwr = 1; csel = CSEL_L0; caddr_wr = 12'd63; cdata_wr = 20'h77777;
      expect_v(1); expect_v(0); expect_v(32'h00123);
      tick();
      cwr = 0;
      check("err_not_run", 32'(err));
      check("cnt0_not_run", 32'(wr_cnt0));
      crd = 1; caddr_rd = 12'd63; #1;
      check("l0_63_intact", 32'(cdata_rd));
      crd = 0;
      busy = 1;
      tick(); tick();
      cwr = 1; caddr_wr = 12'd10; cdata_wr = 20'h0BEEF; expect_v(1);
      tick();
      cwr = 0;
      check("cnt0_run2", 32'(wr_cnt0));

      // reset mid-RUN
      reset = 1; #1;
      expect_v(0); expect_v(32'(ST_IDLE)); expect_v(0); expect_v(0); expect_v(0);
      check("mid_rst_ready", 32'(ready));
      check("mid_rst_state", 32'(dut.state_q));
      check("mid_rst_cnt0", 32'(wr_cnt0));
      check("mid_rst_err", 32'(err));
      check("mid_rst_rb", 32'(rb_data));
      tick();
      reset = 0; busy = 0;
      tick();
      crd = 1; csel = CSEL_L0; caddr_rd = 12'd10; expect_v(32'h0BEEF); #1;
      check("l0_10_kept", 32'(cdata_rd));
      caddr_rd = 12'd63; expect_v(32'h00123); #1;
      check("l0_63_kept", 32'(cdata_rd));
      crd = 0; iaddr = 12'd0; expect_v(32'h0A89E); #1;
      check("img_kept", 32'(idata));

      // counter saturation
      start = 1;
      tick();
      start = 0; busy = 1;
      tick(); tick();
      cwr = 1; csel = CSEL_L1;
      for (int i = 0; i < 2050; i++) begin
         caddr_wr = 12'(i % 1024); cdata_wr = 20'(i);
         tick();
      end
      csel = CSEL_L0;
      for (int i = 0; i < 8194; i++) begin
         caddr_wr = 12'(i); cdata_wr = 20'(i);
         tick();
      end
      cwr = 0;
      expect_v(2047); expect_v(8191); expect_v(0); expect_v(2049);
      check("cnt1_sat", 32'(wr_cnt1));
      check("cnt0_sat", 32'(wr_cnt0));
      check("sat_err", 32'(err));
      crd = 1; csel = CSEL_L1; caddr_rd = 12'd1; #1;
      check("l1_last", 32'(cdata_rd));
      crd = 0; busy = 0;
      repeat (3) tick();

      // watchdog instance: busy never rises
`ifdef CONV_HOST_TIMEOUT_EN
      start2 = 1;
      tick();
      start2 = 0;
      repeat (15) tick();
      expect_v(32'(ST_START)); expect_v(1);
      check("tmo_pre_state", 32'(dut_tmo.state_q));
      check("tmo_pre_ready", 32'(t_ready));
      tick();
      expect_v(32'(ST_TMO)); expect_v(1); expect_v(0);
      check("tmo_state", 32'(dut_tmo.state_q));
      check("tmo_err", 32'(t_err));
      check("tmo_ready", 32'(t_ready));
      repeat (3) tick();
      expect_v(32'(ST_TMO));
      check("tmo_hold", 32'(dut_tmo.state_q));
      start2 = 1;
      tick();
      start2 = 0;
      expect_v(32'(ST_IDLE));
      check("tmo_exit", 32'(dut_tmo.state_q));
`else
      start2 = 1;
      tick();
      start2 = 0;
      repeat (40) tick();
      expect_v(32'(ST_START)); expect_v(1); expect_v(0);
      check("no_tmo_state", 32'(dut_tmo.state_q));
      check("no_tmo_ready", 32'(t_ready));
      check("no_tmo_err", 32'(t_err));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/conv_host.md
CONV_HOST -- requirements
Module: conv_host

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1048576, the watchdog limit in clk cycles while busy is awaited or held.
REQ-002 SHALL have ports: clk  input  1  system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ready  output  1  start request to the convolution engine.
REQ-005 busy  input  1  engine busy flag.
REQ-006 iaddr  input  12  image read address from the engine.
REQ-007 idata  output  20  image pixel returned for iaddr.
REQ-008 cwr, caddr_wr, cdata_wr  input  1/12/20  engine layer-write strobe, address and data.
REQ-009 crd, caddr_rd  input  1/12  engine layer-read strobe and address.
REQ-010 cdata_rd  output  20  layer read data.
REQ-011 csel  input  3  layer select: 3'b001 is L0, 3'b011 is L1.
REQ-012 load_valid, load_addr, load_data  input  1/12/20  image preload port.
REQ-013 start  input  1  launch request.
REQ-014 rb_en, rb_sel, rb_addr  input  1/1/12  readback request; rb_sel 0 is L0, 1 is L1.
REQ-015 rb_data  output  20  readback data; done  output  1  run-complete pulse; err  output  1  sticky protocol error.
REQ-016 wr_cnt0  output  13  and wr_cnt1  output  11  accepted-write counters for L0 and L1.

Function
REQ-017 States SHALL be IDLE, START, RUN, DONE and, when compiled in, TMO.
REQ-018 IDLE: load_valid=1 SHALL write load_data to image[load_addr] at posedge.
- start=1 with load_valid=0 SHALL go to START and clear wr_cnt0, wr_cnt1 and err.
- If load_valid and start are both high, the load SHALL win and start is ignored.
REQ-019 START SHALL drive ready=1 and hold it until busy=1 is sampled.
- On that sample it SHALL drop ready on the next edge and go to RUN.
REQ-020 RUN: busy=0 sampled SHALL go to DONE.
- DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 idata SHALL be a combinational read of image[iaddr] in every state.
REQ-022 cdata_rd SHALL be a combinational read of the bank selected by csel at caddr_rd when crd=1, and 20'h0 otherwise.
- For L1, index is caddr_rd[9:0].
- An unknown csel SHALL return 0.
REQ-023 In RUN with cwr=1, csel=001 SHALL write L0[caddr_wr] at posedge and increment wr_cnt0.
- csel=011 SHALL write L1[caddr_wr[9:0]] and increment wr_cnt1.
REQ-024 Counters SHALL saturate at all-ones, not wrap.
REQ-025 err SHALL be set and held, with no memory write, on any of:
- cwr=1 with another csel;
- cwr=1 to L1 with caddr_wr>=1024;
- cwr=1 outside RUN.
REQ-026 Readback SHALL act only in IDLE.
- rb_en=1 SHALL register rb_data = bank[rb_sel][rb_addr] one cycle later; L1 uses rb_addr[9:0].
- Otherwise rb_data SHALL hold its value.
REQ-027 load_valid, start and rb_en outside their accepting state SHALL be ignored.

Reset
REQ-028 reset=1 SHALL asynchronously force state=IDLE.
- Outputs: ready=0, done=0, err=0, wr_cnt0=0, wr_cnt1=0, rb_data=0.
REQ-029 Memory arrays SHALL NOT be cleared by reset.
- Reset mid-RUN SHALL abort to IDLE, with contents written so far retained.

Configuration
REQ-030 With macro CONV_HOST_TIMEOUT_EN defined, a cycle counter SHALL run in START and RUN, cleared on entry to START.
- Reaching TIMEOUT_CYCLES SHALL enter TMO: ready=0, err=1.
- TMO SHALL be left only to IDLE by start=1.
REQ-031 Without CONV_HOST_TIMEOUT_EN, there SHALL be no counter and no TMO state, and START/RUN wait indefinitely.

Structure
REQ-032 Package conv_host_pkg SHALL hold:
- the state enum;
- CSEL_L0=3'b001 and CSEL_L1=3'b011;
- IMG_DEPTH=4096, L0_DEPTH=4096, L1_DEPTH=1024;
- the 20-bit data width.
REQ-033 Sub-module conv_host_bank SHALL be instantiated 3 times: a parametric-depth memory with synchronous write and asynchronous read.

Verification
REQ-034 Preload image[0]=20'h0A89E and iaddr=0 -> idata=20'h0A89E in the same cycle.
REQ-035 start, engine model raises busy 2 cycles later -> ready high for exactly 3 cycles.
- busy low 100 cycles later -> done pulses 1 cycle, state IDLE.
REQ-036 In RUN: cwr, csel=001, caddr_wr=63, cdata_wr=20'h00123; then crd, caddr_rd=63 -> cdata_rd=20'h00123, wr_cnt0=1.
- Readback rb_sel=0, rb_addr=63 after done -> rb_data=20'h00123 one cycle later.
REQ-037 cwr with csel=011, caddr_wr=1024 -> err=1, L1[0] unchanged, wr_cnt1=0.
REQ-038 Same-cycle load_valid and start in IDLE -> image written, state stays IDLE.
- Reset asserted mid-RUN -> ready=0, IDLE, counters 0, L0 data intact.
REQ-039 With CONV_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16, busy never rises -> TMO after 16 cycles, err=1, ready=0.
